// File: rtl/svm_dwell_time_capture.sv
// Dwell-time capture for a three-state one-hot switching pattern (U_1 -> U_2 -> U_0).
// Reports T_1/T_2/T_0 plus order, one-hot and timeout flags once per sampling window.
module svm_dwell_time_capture #(
  parameter int TAST_PERIOD    = 20000,
  parameter int TIMEOUT_MARGIN = 64,
  parameter int CW             = 15
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          U_0,
  input  logic          U_1,
  input  logic          U_2,
  input  logic          SYNC,
  output logic [CW-1:0] T_1,
  output logic [CW-1:0] T_2,
  output logic [CW-1:0] T_0,
  output logic          VALID,
  output logic          SEQ_ERR,
  output logic          ONEHOT_ERR,
  output logic          TIMEOUT
);

  localparam int LIMIT = TAST_PERIOD + TIMEOUT_MARGIN;
  localparam int WW    = $clog2(LIMIT + 1);
  localparam logic [WW-1:0] LIMIT_W = WW'(LIMIT);
  localparam logic [CW-1:0] CMAX    = {CW{1'b1}};

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] c1_r, c2_r, c0_r, c1_s, c2_s, c0_s;
  logic [WW-1:0] wcnt_r, wcnt_s;
  logic [1:0]    phase_r, phase_s;
  logic          seq_err_r, seq_err_s;
  logic          oh_err_r, oh_err_s;
  logic          close_sync_s, close_tmo_s, count_s;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (v == CMAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CW'(1);
    end
  endfunction

  // Next-state, window open/close decisions and per-cycle sample accounting
  always_comb begin
    state_s      = state_r;
    c1_s         = c1_r;
    c2_s         = c2_r;
    c0_s         = c0_r;
    wcnt_s       = wcnt_r;
    phase_s      = phase_r;
    seq_err_s    = seq_err_r;
    oh_err_s     = oh_err_r;
    close_sync_s = 1'b0;
    close_tmo_s  = 1'b0;
    count_s      = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (SYNC) begin
          state_s = ST_MEASURE;
          count_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_MEASURE: begin
        // SYNC beats a coincident timeout
        if (SYNC) begin
          close_sync_s = 1'b1;
          count_s      = 1'b1;
        end else if (wcnt_r >= LIMIT_W) begin
          close_tmo_s = 1'b1;
          state_s     = ST_IDLE;
        end else begin
          count_s = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // A SYNC cycle is cycle 0 of a fresh window, so clear before counting it
    if (SYNC) begin
      c1_s      = {CW{1'b0}};
      c2_s      = {CW{1'b0}};
      c0_s      = {CW{1'b0}};
      wcnt_s    = {WW{1'b0}};
      phase_s   = 2'd0;
      seq_err_s = 1'b0;
      oh_err_s  = 1'b0;
    end else begin
      wcnt_s = wcnt_s;
    end

    if (count_s) begin
      wcnt_s = wcnt_s + WW'(1);
      case ({U_2, U_1, U_0})
        3'b010: begin
          c1_s = sat_inc(c1_s);
          if (phase_s != 2'd0) begin
            seq_err_s = 1'b1;
          end else begin
            seq_err_s = seq_err_s;
          end
        end
        3'b100: begin
          c2_s = sat_inc(c2_s);
          if (phase_s == 2'd2) begin
            seq_err_s = 1'b1;
          end else begin
            phase_s = 2'd1;
          end
        end
        3'b001: begin
          c0_s    = sat_inc(c0_s);
          phase_s = 2'd2;
        end
        default: begin
          oh_err_s = 1'b1;
        end
      endcase
    end else begin
      wcnt_s = wcnt_s;
    end
  end

  // Window state and accumulators
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r   <= ST_IDLE;
      c1_r      <= {CW{1'b0}};
      c2_r      <= {CW{1'b0}};
      c0_r      <= {CW{1'b0}};
      wcnt_r    <= {WW{1'b0}};
      phase_r   <= 2'd0;
      seq_err_r <= 1'b0;
      oh_err_r  <= 1'b0;
    end else begin
      state_r   <= state_s;
      c1_r      <= c1_s;
      c2_r      <= c2_s;
      c0_r      <= c0_s;
      wcnt_r    <= wcnt_s;
      phase_r   <= phase_s;
      seq_err_r <= seq_err_s;
      oh_err_r  <= oh_err_s;
    end
  end

  // Result registers: load on window close, otherwise hold
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      T_1        <= {CW{1'b0}};
      T_2        <= {CW{1'b0}};
      T_0        <= {CW{1'b0}};
      VALID      <= 1'b0;
      SEQ_ERR    <= 1'b0;
      ONEHOT_ERR <= 1'b0;
      TIMEOUT    <= 1'b0;
    end else if (close_sync_s || close_tmo_s) begin
      T_1        <= c1_r;
      T_2        <= c2_r;
      T_0        <= c0_r;
      VALID      <= 1'b1;
      SEQ_ERR    <= seq_err_r;
      ONEHOT_ERR <= oh_err_r;
      TIMEOUT    <= close_tmo_s;
    end else begin
      VALID <= 1'b0;
    end
  end

endmodule
